// File: rtl/cfg_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_chain_loader
//  Description : Collects layer configuration frames from a host word stream
//                and shifts each frame, LSB first, into a serial configuration
//                chain. NLAYER frames are loaded per START request; a one-cycle
//                gap separates frames and DONE pulses once after the last one.
//
//  Ports
//    clk_i         single clock, all state updates on the rising edge
//    rstb_i        synchronous active-low reset
//    start_i       one-cycle request to begin a load sequence (IDLE only)
//    abort_i       cancels a running sequence, returns to IDLE
//    wr_valid_i    host word valid
//    wr_ready_o    word accepted this cycle (high only while loading)
//    wr_data_i     frame word k carries frame bits [k*WORD_WIDTH +: WORD_WIDTH]
//    cfg_we_o      serial chain write enable (registered)
//    cfg_d_o       serial chain data (registered)
//    busy_o        high in every state except IDLE
//    done_o        one-cycle pulse after the final frame has been shifted
//    layer_o       index of the frame being loaded or shifted
//
//  Revision    : 1.0  initial release
// ============================================================================
module cfg_chain_loader #(
    parameter int FRAME_WIDTH = 128,
    parameter int WORD_WIDTH  = 16,
    parameter int NLAYER      = 5
) (
    input  logic                  clk_i,
    input  logic                  rstb_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    output logic                  cfg_we_o,
    output logic                  cfg_d_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2:0]            layer_o
);

    localparam int NWORDS = FRAME_WIDTH / WORD_WIDTH;
    localparam int WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int BCW    = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

    localparam logic [WCW-1:0] LAST_WORD  = WCW'(NWORDS - 1);
    localparam logic [BCW-1:0] LAST_BIT   = BCW'(FRAME_WIDTH - 1);
    localparam logic [2:0]     LAST_LAYER = 3'(NLAYER - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             layer_q, layer_d;
    logic [WCW-1:0]         wcnt_q,  wcnt_d;
    logic [BCW-1:0]         bcnt_q,  bcnt_d;
    logic [FRAME_WIDTH-1:0] frame_q, frame_d;
    logic                   cfg_we_q, cfg_we_d;
    logic                   cfg_d_q,  cfg_d_d;
    logic                   w_accept;

    // Ready depends only on the registered state so the host sees a clean
    // handshake; a word is consumed on any LOAD cycle with valid high.
    assign w_accept = (state_q == ST_LOAD) && wr_valid_i;

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        frame_d = frame_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    layer_d = 3'd0;
                    wcnt_d  = '0;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    frame_d[int'(wcnt_q) * WORD_WIDTH +: WORD_WIDTH] = wr_data_i;
                    if (wcnt_q == LAST_WORD) begin
                        state_d = ST_SHIFT;
                        bcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (bcnt_q == LAST_BIT) begin
                    state_d = ST_GAP;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (layer_q == LAST_LAYER) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_LOAD;
                    layer_d = layer_q + 3'd1;
                    wcnt_d  = '0;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every other transition of a running sequence.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // Chain outputs are registered from next-state values so the first
    // enabled cycle lines up with entry into SHIFT. frame_d already holds
    // the word written on the final handshake, so bit 0 is always current.
    always_comb begin
        cfg_we_d = (state_d == ST_SHIFT);
        cfg_d_d  = (state_d == ST_SHIFT) ? frame_d[bcnt_d] : 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rstb_i) begin
            state_q  <= ST_IDLE;
            layer_q  <= 3'd0;
            wcnt_q   <= '0;
            bcnt_q   <= '0;
            frame_q  <= '0;
            cfg_we_q <= 1'b0;
            cfg_d_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            wcnt_q   <= wcnt_d;
            bcnt_q   <= bcnt_d;
            frame_q  <= frame_d;
            cfg_we_q <= cfg_we_d;
            cfg_d_q  <= cfg_d_d;
        end
    end

    assign wr_ready_o = (state_q == ST_LOAD);
    assign cfg_we_o   = cfg_we_q;
    assign cfg_d_o    = cfg_d_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_FIN);
    assign layer_o    = layer_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_chain_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cfg_chain_loader
//  Description : Self-checking bench for cfg_chain_loader. A control table
//                exercises reset/start/abort handling, hand sequences cover
//                reset mid-load and mid-shift, and randomized host traffic is
//                compared against a frame-stream reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cfg_chain_loader;

    localparam int FW = 128;
    localparam int WW = 16;
    localparam int NL = 5;
    localparam int NW = FW / WW;

    logic          clk = 1'b0;
    logic          rstb, start, abort, wr_valid;
    logic          wr_ready, cfg_we, cfg_d, busy, done;
    logic [WW-1:0] wr_data;
    logic [2:0]    layer;

    always #5 clk = ~clk;

    cfg_chain_loader #(
        .FRAME_WIDTH(FW),
        .WORD_WIDTH (WW),
        .NLAYER     (NL)
    ) dut (
        .clk_i     (clk),
        .rstb_i    (rstb),
        .start_i   (start),
        .abort_i   (abort),
        .wr_valid_i(wr_valid),
        .wr_ready_o(wr_ready),
        .wr_data_i (wr_data),
        .cfg_we_o  (cfg_we),
        .cfg_d_o   (cfg_d),
        .busy_o    (busy),
        .done_o    (done),
        .layer_o   (layer)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [FW-1:0] frames [NL];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] word_of(input int p);
        logic [FW-1:0] f;
        f = frames[p / NW];
        return f[(p % NW) * WW +: WW];
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    // Frame with the documented field values; NCFG is random filler.
    function automatic logic [FW-1:0] field_frame();
        logic [FW-1:0] f;
        f = rand_frame();
        f[4:0]     = 5'd3;
        f[9:5]     = 5'd7;
        f[14:10]   = 5'd7;
        f[23:15]   = 9'd7;
        f[123:120] = 4'd10;
        f[124]     = 1'b1;
        f[125]     = 1'b1;
        f[126]     = 1'b0;
        f[127]     = 1'b0;
        return f;
    endfunction

    // Host offers the next word of the flattened frame list every cycle it
    // chooses to be valid; the expected chain stream is simply every frame
    // bit, LSB first, frame 0 first.
    task automatic run_seq(input string tag, input int valid_pct,
                           input bit noise_start, input bit do_abort);
        bit exp_bits[$];
        bit got_bits[$];
        int ptr = 0, cyc = 0, dones = 0, runs = 0, runlen = 0;
        int done_cyc = -1, layer_errs = 0, idle_d_errs = 0, mm;
        bit hs, prev_we = 1'b0, stop = 1'b0, aborted = 1'b0;

        for (int f = 0; f < NL; f++)
            for (int b = 0; b < FW; b++) exp_bits.push_back(frames[f][b]);

        start = 1'b1; abort = 1'b0; wr_valid = 1'b0;
        tick();
        start = 1'b0;
        while (!stop && cyc < 4000) begin
            wr_valid = ($urandom_range(99) < valid_pct);
            wr_data  = (ptr < NL * NW) ? word_of(ptr) : WW'($urandom);
            start    = noise_start && busy && ($urandom_range(15) == 0);
            abort    = do_abort && cfg_we && (got_bits.size() == 2 * FW + 61);
            hs       = wr_valid && wr_ready;
            if (hs && int'(layer) != ptr / NW) layer_errs++;
            tick();
            cyc++;
            if (abort) begin
                aborted = 1'b1;
                stop    = 1'b1;
            end else begin
                if (hs) begin
                    ptr++;
                    if (ptr % NW == 0)
                        check({tag, "_we_after_last_word"}, int'(cfg_we), 1);
                end
                if (cfg_we) begin
                    got_bits.push_back(cfg_d);
                    runlen++;
                end else begin
                    if (cfg_d) idle_d_errs++;
                    if (prev_we) begin
                        runs++;
                        check({tag, "_shift_len"}, runlen, FW);
                        runlen = 0;
                    end
                end
                prev_we = cfg_we;
                if (done) begin
                    dones++;
                    done_cyc = cyc;
                    stop = 1'b1;
                end
            end
        end
        start = 1'b0; abort = 1'b0; wr_valid = 1'b0;

        if (do_abort) check({tag, "_abort_reached"}, int'(aborted), 1);
        if (aborted) begin
            check({tag, "_abort_we"},    int'(cfg_we),   0);
            check({tag, "_abort_d"},     int'(cfg_d),    0);
            check({tag, "_abort_busy"},  int'(busy),     0);
            check({tag, "_abort_ready"}, int'(wr_ready), 0);
            mm = 0;
            for (int i = 0; i < got_bits.size(); i++)
                if (got_bits[i] != exp_bits[i]) mm++;
            check({tag, "_abort_prefix_bits"}, mm, 0);
            for (int i = 0; i < 20; i++) begin
                tick();
                if (done) dones++;
            end
            check({tag, "_abort_no_done"}, dones, 0);
            check({tag, "_abort_idle_busy"}, int'(busy), 0);
        end else begin
            check({tag, "_done_count"}, dones, 1);
            check({tag, "_bit_count"}, got_bits.size(), NL * FW);
            for (int f = 0; f < NL; f++) begin
                mm = 0;
                for (int b = 0; b < FW; b++)
                    if (f * FW + b >= got_bits.size() ||
                        got_bits[f * FW + b] != exp_bits[f * FW + b]) mm++;
                check($sformatf("%s_frame%0d_bits", tag, f), mm, 0);
            end
            check({tag, "_shift_runs"}, runs, NL);
            check({tag, "_layer_at_load"}, layer_errs, 0);
            check({tag, "_idle_d_zero"}, idle_d_errs, 0);
            if (valid_pct == 100) check({tag, "_latency"}, done_cyc, 685);
            tick();
            check({tag, "_post_busy"}, int'(busy), 0);
            check({tag, "_post_done"}, int'(done), 0);
            check({tag, "_post_ready"}, int'(wr_ready), 0);
        end
    endtask

    typedef struct {
        string      name;
        bit         rstb, start, abort, valid;
        bit         e_busy, e_ready, e_we, e_done;
        logic [2:0] e_layer;
    } vec_t;

    vec_t vecs [10];
    int   dcount;

    initial begin
        rstb = 1'b0; start = 1'b0; abort = 1'b0; wr_valid = 1'b0; wr_data = '0;

        //           name              rstb st ab vl  busy rdy we done layer
        vecs[0] = '{"reset",           0, 0, 0, 0,  0, 0, 0, 0, 3'd0};
        vecs[1] = '{"idle_abort",      1, 0, 1, 0,  0, 0, 0, 0, 3'd0};
        vecs[2] = '{"start_and_abort", 1, 1, 1, 0,  1, 1, 0, 0, 3'd0};
        vecs[3] = '{"load_stall",      1, 0, 0, 0,  1, 1, 0, 0, 3'd0};
        vecs[4] = '{"load_word",       1, 0, 0, 1,  1, 1, 0, 0, 3'd0};
        vecs[5] = '{"abort_in_load",   1, 0, 1, 0,  0, 0, 0, 0, 3'd0};
        vecs[6] = '{"restart",         1, 1, 0, 0,  1, 1, 0, 0, 3'd0};
        vecs[7] = '{"start_in_load",   1, 1, 0, 0,  1, 1, 0, 0, 3'd0};
        vecs[8] = '{"reset_in_load",   0, 0, 0, 1,  0, 0, 0, 0, 3'd0};
        vecs[9] = '{"idle_after_rst",  1, 0, 0, 0,  0, 0, 0, 0, 3'd0};

        for (int i = 0; i < 10; i++) begin
            rstb = vecs[i].rstb; start = vecs[i].start;
            abort = vecs[i].abort; wr_valid = vecs[i].valid;
            wr_data = 16'h5A5A;
            tick();
            check({vecs[i].name, "_busy"},  int'(busy),     int'(vecs[i].e_busy));
            check({vecs[i].name, "_ready"}, int'(wr_ready), int'(vecs[i].e_ready));
            check({vecs[i].name, "_we"},    int'(cfg_we),   int'(vecs[i].e_we));
            check({vecs[i].name, "_done"},  int'(done),     int'(vecs[i].e_done));
            check({vecs[i].name, "_layer"}, int'(layer),    int'(vecs[i].e_layer));
        end
        start = 1'b0; abort = 1'b0; wr_valid = 1'b0;

        // Reset while the fourth word of a frame is being offered.
        start = 1'b1; tick(); start = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 16'(i + 1);
            tick();
        end
        rstb = 1'b0; wr_data = 16'hFFFF;
        tick();
        rstb = 1'b1; wr_valid = 1'b0;
        check("rst_load_busy",  int'(busy),     0);
        check("rst_load_ready", int'(wr_ready), 0);
        check("rst_load_we",    int'(cfg_we),   0);
        check("rst_load_d",     int'(cfg_d),    0);
        check("rst_load_done",  int'(done),     0);
        check("rst_load_layer", int'(layer),    0);

        // Reset part-way through the first shift truncates the chain write.
        start = 1'b1; tick(); start = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < NW; i++) begin
            wr_data = 16'(i * 3 + 1);
            tick();
        end
        wr_valid = 1'b0;
        check("rst_shift_started", int'(cfg_we), 1);
        repeat (10) tick();
        rstb = 1'b0; tick(); rstb = 1'b1;
        check("rst_shift_we",   int'(cfg_we), 0);
        check("rst_shift_busy", int'(busy),   0);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || cfg_we) dcount++;
        end
        check("rst_shift_quiet", dcount, 0);

        // Documented field values, back-to-back host words: minimum latency.
        for (int f = 0; f < NL; f++) frames[f] = field_frame();
        run_seq("fields", 100, 1'b0, 1'b0);

        // First frame begins 1,1,1,1,1 then zeros; stalls and stray STARTs.
        frames[0] = '0;
        frames[0][4:0] = 5'h1F;
        for (int f = 1; f < NL; f++) frames[f] = rand_frame();
        run_seq("ones5", 60, 1'b1, 1'b0);

        // Abort at bit 60 of frame 2, then a clean full reload.
        for (int f = 0; f < NL; f++) frames[f] = rand_frame();
        run_seq("abort", 50, 1'b0, 1'b1);
        for (int f = 0; f < NL; f++) frames[f] = rand_frame();
        run_seq("after_abort", 100, 1'b0, 1'b0);

        // Heavily stalled host.
        for (int f = 0; f < NL; f++) frames[f] = rand_frame();
        run_seq("stalled", 30, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
